wash_phase_timer: RTL



---
 rtl/wash_phase_timer_if.sv | 25 ++
 rtl/wash_phase_timer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase timer signal bundle.
// master = controller side (drives run/lock/clear), slave = the timer.
interface wash_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             cycle_run;
    logic             spin_run;
    logic             door_lock;
    logic             fault_clr;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             fault;

    modport master (
        output cycle_run, spin_run, door_lock, fault_clr,
        input  cycle_timeout, spin_timeout, remaining, busy, fault
    );

    modport slave (
        input  cycle_run, spin_run, door_lock, fault_clr,
        output cycle_timeout, spin_timeout, remaining, busy, fault
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Wash/spin phase timer: counts prescaled ticks for the active phase,
// raises the matching timeout on expiry, and latches a fault if the
// door lock drops while a phase is being timed. All outputs registered.
module wash_phase_timer #(
    parameter int PRESCALE    = 1000,
    parameter int CNT_W       = 16,
    parameter int CYCLE_TICKS = 300,
    parameter int SPIN_TICKS  = 120
) (
    input  logic               clk,
    input  logic               reset,
    wash_phase_timer_if.slave  bus
);
    // A prescaler of 1 still needs a 1-bit register; it simply stays at 0.
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CYC_N    = CNT_W'(CYCLE_TICKS);
    localparam logic [CNT_W-1:0] SPN_N    = CNT_W'(SPIN_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CYCLE,
        S_SPIN,
        S_EXPIRED,
        S_FAULT
    } state_t;

    state_t           r_state, w_state;
    logic [PW-1:0]    r_pre,   w_pre;
    logic [CNT_W-1:0] r_rem,   w_rem;
    logic             r_cto,   w_cto;
    logic             r_sto,   w_sto;
    logic             r_busy,  w_busy;
    logic             r_fault, w_fault;

    // Run input that belongs to the phase currently timed / expired.
    logic w_phase_run;
    logic w_exp_run;

    assign w_phase_run = (r_state == S_CYCLE) ? bus.cycle_run : bus.spin_run;
    assign w_exp_run   = r_cto ? bus.cycle_run : bus.spin_run;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_rem   <= '0;
            r_cto   <= 1'b0;
            r_sto   <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_rem   <= w_rem;
            r_cto   <= w_cto;
            r_sto   <= w_sto;
            r_busy  <= w_busy;
            r_fault <= w_fault;
        end
    end

    // Next-state and next-output logic. Within a timed phase the priority is
    // door-lock loss, then abort, then tick/expiry.
    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_rem   = r_rem;
        w_cto   = r_cto;
        w_sto   = r_sto;
        w_busy  = r_busy;
        w_fault = r_fault;

        case (r_state)
            S_IDLE: begin
                if (bus.cycle_run) begin
                    w_state = S_CYCLE;
                    w_rem   = CYC_N;
                    w_pre   = '0;
                    w_busy  = 1'b1;
                end else if (bus.spin_run) begin
                    w_state = S_SPIN;
                    w_rem   = SPN_N;
                    w_pre   = '0;
                    w_busy  = 1'b1;
                end
            end

            S_CYCLE, S_SPIN: begin
                if (!bus.door_lock) begin
                    // remaining is left as-is so the fault shows where it hit
                    w_state = S_FAULT;
                    w_fault = 1'b1;
                    w_busy  = 1'b0;
                    w_cto   = 1'b0;
                    w_sto   = 1'b0;
                end else if (!w_phase_run) begin
                    w_state = S_IDLE;
                    w_rem   = '0;
                    w_pre   = '0;
                    w_busy  = 1'b0;
                end else if (r_pre == PRE_LAST) begin
                    w_pre = '0;
                    if (r_rem <= CNT_W'(1)) begin
                        w_state = S_EXPIRED;
                        w_rem   = '0;
                        w_busy  = 1'b0;
                        w_cto   = (r_state == S_CYCLE);
                        w_sto   = (r_state == S_SPIN);
                    end else begin
                        w_rem = r_rem - CNT_W'(1);
                    end
                end else begin
                    w_pre = r_pre + PW'(1);
                end
            end

            S_EXPIRED: begin
                if (!w_exp_run) begin
                    w_state = S_IDLE;
                    w_cto   = 1'b0;
                    w_sto   = 1'b0;
                end
            end

            S_FAULT: begin
                if (bus.fault_clr && !bus.cycle_run && !bus.spin_run) begin
                    w_state = S_IDLE;
                    w_fault = 1'b0;
                    w_rem   = '0;
                    w_pre   = '0;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_pre   = '0;
                w_rem   = '0;
                w_cto   = 1'b0;
                w_sto   = 1'b0;
                w_busy  = 1'b0;
                w_fault = 1'b0;
            end
        endcase
    end

    assign bus.cycle_timeout = r_cto;
    assign bus.spin_timeout  = r_sto;
    assign bus.remaining     = r_rem;
    assign bus.busy          = r_busy;
    assign bus.fault         = r_fault;

endmodule
